// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and instruction-memory
// fetch sequencer for the 8-bit CPU. One fetch in flight at a time over a
// req/ack handshake; HALTED is sticky until reset.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_we,
    input  logic              pc_sel,
    input  logic              pc_jmp_sel,
    input  logic [3:0]        pc_offset,
    input  logic              ir_we,
    input  logic              halt,
    input  logic [7:0]        imem_rdata,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        instr,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              start_fetch;
    logic              ack_take;
    logic              pc_upd;
    logic [ADDR_W-1:0] pc_nxt;

    // Request and busy are exactly "a fetch is outstanding", i.e. the WAIT state.
    assign imem_req   = (state == S_WAIT);
    assign fetch_busy = (state == S_WAIT);
    assign halted     = (state == S_HALTED);

    // State register; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: halt beats ir_we in IDLE; halt in WAIT waits for the ack.
    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        ack_take    = 1'b0;
        case (state)
            S_IDLE: begin
                if (halt) begin
                    state_nxt = S_HALTED;
                end else if (ir_we) begin
                    state_nxt   = S_WAIT;
                    start_fetch = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = halt ? S_HALTED : S_IDLE;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // PC arithmetic: increment, signed 4-bit relative jump, or zero-extended absolute.
    always_comb begin
        pc_upd = pc_we && (state != S_HALTED);
        pc_nxt = pc;
        if (!pc_sel)
            pc_nxt = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        else if (!pc_jmp_sel)
            pc_nxt = pc + {{(ADDR_W-4){pc_offset[3]}}, pc_offset};
        else
            pc_nxt = {{(ADDR_W-4){1'b0}}, pc_offset};
    end

    // Datapath registers: fetch address is captured from the pre-update PC,
    // so a same-edge or in-flight PC change never disturbs the fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            instr      <= 8'h00;
            imem_addr  <= '0;
            fetch_done <= 1'b0;
        end else begin
            fetch_done <= ack_take;
            if (pc_upd)      pc        <= pc_nxt;
            if (start_fetch) imem_addr <= pc;
            if (ack_take)    instr     <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset state, handshake timing, PC modes,
// halt deferral and asynchronous reset during a fetch.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pc_we, pc_sel, pc_jmp_sel, ir_we, halt, imem_ack;
    logic [3:0] pc_offset;
    logic [7:0] imem_rdata;
    logic       imem_req, fetch_busy, fetch_done, halted;
    logic [7:0] imem_addr, instr, pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       sel;
        logic       jmp;
        logic [3:0] off;
        logic [7:0] exp_pc;
    } pc_vec_t;

    pc_vec_t vecs[16];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .pc_jmp_sel(pc_jmp_sel),
        .pc_offset (pc_offset),
        .ir_we     (ir_we),
        .halt      (halt),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .instr     (instr),
        .pc        (pc),
        .fetch_busy(fetch_busy),
        .fetch_done(fetch_done),
        .halted    (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // PC mode table, applied cumulatively starting from pc = 0.
        vecs[0]  = '{1'b1, 1'b1, 4'hF, 8'h0F}; // absolute F
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 8'h10}; // increment
        vecs[2]  = '{1'b1, 1'b0, 4'h8, 8'h08}; // 0x10 + (-8)
        vecs[3]  = '{1'b1, 1'b1, 4'hF, 8'h0F};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 8'h10};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 8'h11}; // 0x10 + 1
        vecs[6]  = '{1'b1, 1'b1, 4'hF, 8'h0F};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 8'h10};
        vecs[8]  = '{1'b1, 1'b1, 4'hF, 8'h0F}; // absolute from 0x10
        vecs[9]  = '{1'b1, 1'b1, 4'h0, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 4'hF, 8'hFF}; // 0 + (-1) wraps
        vecs[11] = '{1'b0, 1'b0, 4'h0, 8'h00}; // 0xFF + 1 wraps
        vecs[12] = '{1'b1, 1'b1, 4'h2, 8'h02};
        vecs[13] = '{1'b1, 1'b0, 4'hC, 8'hFE}; // 2 + (-4)
        vecs[14] = '{1'b1, 1'b0, 4'h7, 8'h05}; // 0xFE + 7 wraps
        vecs[15] = '{1'b0, 1'b0, 4'h0, 8'h06};

        rst_n = 1'b0; pc_we = 0; pc_sel = 0; pc_jmp_sel = 0; pc_offset = 4'h0;
        ir_we = 0; halt = 0; imem_ack = 0; imem_rdata = 8'h00;
        #1;
        check("rst_pc", pc, 8'h00);
        check("rst_instr", instr, 8'h00);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_req", imem_req, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_done", fetch_done, 0);
        check("rst_halted", halted, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // Single fetch, ack one cycle after the request.
        ir_we = 1; tick; ir_we = 0;
        check("f1_req", imem_req, 1);
        check("f1_busy", fetch_busy, 1);
        check("f1_addr", imem_addr, 8'h00);
        check("f1_instr_early", instr, 8'h00);
        imem_ack = 1; imem_rdata = 8'h6F; tick; imem_ack = 0; imem_rdata = 8'h00;
        check("f1_instr", instr, 8'h6F);
        check("f1_done", fetch_done, 1);
        check("f1_busy_off", fetch_busy, 0);
        check("f1_req_off", imem_req, 0);
        tick;
        check("f1_done_pulse", fetch_done, 0);
        check("f1_instr_hold", instr, 8'h6F);

        // Delayed ack with a redundant ir_we mid-wait.
        ir_we = 1; tick; ir_we = 0;
        for (int c = 0; c < 3; c++) begin
            check("f2_req_held", imem_req, 1);
            check("f2_addr_held", imem_addr, 8'h00);
            check("f2_no_done", fetch_done, 0);
            ir_we = (c == 1);
            tick;
            ir_we = 0;
        end
        check("f2_req_held4", imem_req, 1);
        imem_ack = 1; imem_rdata = 8'hA5; tick; imem_ack = 0;
        check("f2_instr", instr, 8'hA5);
        check("f2_done", fetch_done, 1);
        tick;
        check("f2_single_fetch", imem_req, 0);
        check("f2_done_pulse", fetch_done, 0);

        // PC update modes.
        for (int i = 0; i < 16; i++) begin
            pc_we = 1; pc_sel = vecs[i].sel; pc_jmp_sel = vecs[i].jmp; pc_offset = vecs[i].off;
            tick;
            check($sformatf("pc_vec%0d", i), pc, vecs[i].exp_pc);
            check($sformatf("pc_vec%0d_noreq", i), imem_req, 0);
        end
        pc_we = 0;

        // Same-edge ir_we and pc_we, then a PC change during WAIT.
        pc_we = 1; pc_sel = 1; pc_jmp_sel = 1; pc_offset = 4'h5; tick;
        check("se_pc_setup", pc, 8'h05);
        pc_sel = 0; ir_we = 1; tick; ir_we = 0;
        check("se_addr", imem_addr, 8'h05);
        check("se_pc", pc, 8'h06);
        check("se_req", imem_req, 1);
        tick; pc_we = 0;
        check("wait_pc", pc, 8'h07);
        check("wait_addr", imem_addr, 8'h05);
        imem_ack = 1; imem_rdata = 8'h3C; tick; imem_ack = 0;
        check("se_instr", instr, 8'h3C);

        // Halt during WAIT is deferred until the ack.
        ir_we = 1; tick; ir_we = 0; halt = 1;
        tick;
        check("h_req_wait", imem_req, 1);
        check("h_not_halted", halted, 0);
        imem_ack = 1; imem_rdata = 8'h14; tick; imem_ack = 0;
        check("h_instr", instr, 8'h14);
        check("h_halted", halted, 1);
        check("h_done", fetch_done, 1);
        check("h_req_off", imem_req, 0);
        halt = 0; ir_we = 1; pc_we = 1; pc_sel = 0; imem_ack = 1; imem_rdata = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick;
            check("h_no_req", imem_req, 0);
            check("h_pc_frozen", pc, 8'h07);
            check("h_instr_frozen", instr, 8'h14);
            check("h_stay", halted, 1);
        end
        ir_we = 0; pc_we = 0; imem_ack = 0;

        // Asynchronous reset mid-WAIT, then a stale ack.
        rst_n = 0; #1;
        check("r0_halted", halted, 0);
        rst_n = 1;
        tick;
        ir_we = 1; tick; ir_we = 0;
        check("r_req", imem_req, 1);
        #2; rst_n = 0; #1;
        check("r_req_async", imem_req, 0);
        check("r_busy_async", fetch_busy, 0);
        check("r_pc", pc, 8'h00);
        check("r_instr", instr, 8'h00);
        tick;
        rst_n = 1; imem_ack = 1; imem_rdata = 8'h77;
        tick; imem_ack = 0;
        check("r_stale_instr", instr, 8'h00);
        check("r_stale_done", fetch_done, 0);
        check("r_stale_req", imem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
